// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared encodings and constants for the sequential divider
package seq_divider_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [DATA_W-1:0] MIN_INT  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

endpackage

// File: rtl/div_trial_sub.sv
// rtl/div_trial_sub.sv - combinational trial subtractor; BorrowOut picks each quotient bit
module div_trial_sub #(
  parameter int Width = 33
) (
  input  logic [Width-1:0] Minuend,
  input  logic [Width-1:0] Subtrahend,
  input  logic             BorrowIn,
  output logic [Width-1:0] Difference,
  output logic             BorrowOut
);

  assign {BorrowOut, Difference} = {1'b0, Minuend} - {1'b0, Subtrahend} - {{Width{1'b0}}, BorrowIn};

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - fixed-latency restoring divider for DIV/DIVU/REM/REMU
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int NrOfBits = DATA_W
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                Start,
  input  logic [1:0]          Op,
  input  logic [NrOfBits-1:0] Dividend,
  input  logic [NrOfBits-1:0] Divisor,
  output logic                Busy,
  output logic                Done,
  output logic [NrOfBits-1:0] Result
);

  localparam int CntW = $clog2(NrOfBits) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NrOfBits - 1);
  localparam logic [NrOfBits-1:0] MinIntW  = MIN_INT[DATA_W-1 -: NrOfBits];
  localparam logic [NrOfBits-1:0] AllOnesW = ALL_ONES[NrOfBits-1:0];

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [NrOfBits-1:0] q_q, q_d;
  logic [NrOfBits:0]   r_q, r_d;
  logic [NrOfBits-1:0] d_q, d_d;
  logic [NrOfBits-1:0] dividend_q, dividend_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;
  logic [NrOfBits-1:0] result_q, result_d;

  logic                accept;
  logic [NrOfBits:0]   trial;
  logic [NrOfBits:0]   trial_diff;
  logic                trial_borrow;
  logic [NrOfBits-1:0] quo_fix;
  logic [NrOfBits-1:0] rem_fix;
  logic                unused_r_msb;

  assign accept       = Start && (state_q == S_IDLE || state_q == S_DONE);
  assign trial        = {r_q[NrOfBits-1:0], q_q[NrOfBits-1]};
  // R never exceeds D, so its top bit only exists to hold the trial difference width
  assign unused_r_msb = r_q[NrOfBits];

  div_trial_sub #(
    .Width(NrOfBits + 1)
  ) u_trial_sub (
    .Minuend   (trial),
    .Subtrahend({1'b0, d_q}),
    .BorrowIn  (1'b0),
    .Difference(trial_diff),
    .BorrowOut (trial_borrow)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_CALC;
      S_CALC:  if (cnt_q == CntLast) state_d = S_FIXUP;
      S_FIXUP: state_d = S_DONE;
      S_DONE:  state_d = Start ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q == S_CALC) || (state_q == S_FIXUP);
    Done = (state_q == S_DONE);
  end

  // Divide-by-zero outranks overflow; a signed divisor of -1 leaves D == 1 with sB set
  always_comb begin
    quo_fix = (sa_q ^ sb_q) ? -q_q : q_q;
    rem_fix = sa_q ? -r_q[NrOfBits-1:0] : r_q[NrOfBits-1:0];
    if (d_q == '0) begin
      quo_fix = AllOnesW;
      rem_fix = dividend_q;
    end else if (!op_q[0] && dividend_q == MinIntW && sb_q && d_q == NrOfBits'(1)) begin
      quo_fix = MinIntW;
      rem_fix = '0;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    op_d       = op_q;
    q_d        = q_q;
    r_d        = r_q;
    d_d        = d_q;
    dividend_d = dividend_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    result_d   = result_q;
    if (accept) begin
      op_d       = Op;
      dividend_d = Dividend;
      sa_d       = !Op[0] && Dividend[NrOfBits-1];
      sb_d       = !Op[0] && Divisor[NrOfBits-1];
      q_d        = sa_d ? -Dividend : Dividend;
      d_d        = sb_d ? -Divisor : Divisor;
      r_d        = '0;
      cnt_d      = '0;
    end else if (state_q == S_CALC) begin
      r_d   = trial_borrow ? trial : trial_diff;
      q_d   = {q_q[NrOfBits-2:0], !trial_borrow};
      cnt_d = cnt_q + CntW'(1);
    end else if (state_q == S_FIXUP) begin
      result_d = op_q[1] ? rem_fix : quo_fix;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cnt_q      <= '0;
      op_q       <= '0;
      q_q        <= '0;
      r_q        <= '0;
      d_q        <= '0;
      dividend_q <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      result_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      q_q        <= q_d;
      r_q        <= r_d;
      d_q        <= d_d;
      dividend_q <= dividend_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      result_q   <= result_d;
    end
  end

  assign Result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider
module tb_seq_divider;
  import seq_divider_pkg::*;

  logic        Clock;
  logic        nReset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  int          checks;
  int          failures;
  int          cyc;
  int          done_cnt;
  logic [31:0] done_val;
  logic [31:0] exp_q[$];
  int          issue_q[$];

  seq_divider #(.NrOfBits(32)) dut (
    .Clock   (Clock),
    .nReset  (nReset),
    .Start   (Start),
    .Op      (Op),
    .Dividend(Dividend),
    .Divisor (Divisor),
    .Busy    (Busy),
    .Done    (Done),
    .Result  (Result)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge Clock);
      cyc = cyc + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] quo;
    logic [31:0] rem;
    if (b == 32'd0) begin
      quo = 32'hffff_ffff;
      rem = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      quo = 32'h8000_0000;
      rem = 32'd0;
    end else if (!op[0]) begin
      quo = $signed(a) / $signed(b);
      rem = $signed(a) % $signed(b);
    end else begin
      quo = a / b;
      rem = a % b;
    end
    return op[1] ? rem : quo;
  endfunction

  // Monitor: every Done pops one expected result and its issue cycle
  initial begin
    done_cnt = 0;
    done_val = 32'd0;
    forever begin
      @(negedge Clock);
      if (nReset && Done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_done", 32'd1, 32'd0);
        end else begin
          done_val = exp_q.pop_front();
          check_eq("result", Result, done_val);
          check_eq("latency", 32'(cyc - issue_q.pop_front()), 32'd34);
        end
      end
    end
  end

  // Called at a negedge while the DUT is IDLE or DONE
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    Start    = 1'b1;
    Op       = op;
    Dividend = a;
    Divisor  = b;
    exp_q.push_back(exp);
    issue_q.push_back(cyc);
    @(negedge Clock);
    Start    = 1'b0;
    Op       = 2'($urandom);
    Dividend = $urandom;
    Divisor  = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!Done && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (!Done) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    @(negedge Clock);
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          saved;
    checks   = 0;
    failures = 0;
    nReset   = 1'b0;
    Start    = 1'b0;
    Op       = 2'b00;
    Dividend = 32'd0;
    Divisor  = 32'd0;
    repeat (3) @(negedge Clock);
    check_eq("reset_busy", 32'(Busy), 32'd0);
    check_eq("reset_done", 32'(Done), 32'd0);
    check_eq("reset_result", Result, 32'd0);
    nReset = 1'b1;
    @(negedge Clock);

    issue(OP_DIVU, 32'd100, 32'd7, 32'd14);
    check_eq("busy_after_start", 32'(Busy), 32'd1);
    wait_drain();
    issue(OP_REMU, 32'd100, 32'd7, 32'd2);
    wait_drain();

    issue(OP_DIV, 32'hffff_fff9, 32'd2, 32'hffff_fffd);
    wait_drain();
    issue(OP_REM, 32'hffff_fff9, 32'd2, 32'hffff_ffff);
    wait_drain();
    issue(OP_REM, 32'd7, 32'hffff_fffe, 32'd1);
    wait_drain();

    issue(OP_DIVU, 32'd5, 32'd0, 32'hffff_ffff);
    wait_drain();
    issue(OP_REM, 32'd5, 32'd0, 32'd5);
    wait_drain();

    issue(OP_DIV, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000);
    wait_drain();
    issue(OP_REM, 32'h8000_0000, 32'hffff_ffff, 32'd0);
    wait_drain();

    // Start mid-operation must be ignored
    saved = done_cnt;
    issue(OP_DIVU, 32'd1000, 32'd10, 32'd100);
    repeat (8) @(negedge Clock);
    Start    = 1'b1;
    Op       = OP_DIVU;
    Dividend = 32'd9;
    Divisor  = 32'd3;
    @(negedge Clock);
    Start = 1'b0;
    check_eq("busy_ignored_start", 32'(Busy), 32'd1);
    check_eq("result_held", Result, 32'd0);
    wait_drain();
    repeat (40) @(negedge Clock);
    check_eq("single_done", 32'(done_cnt - saved), 32'd1);

    // Back-to-back: Start during the Done cycle
    issue(OP_DIVU, 32'd77, 32'd5, 32'd15);
    wait_done();
    issue(OP_REMU, 32'd77, 32'd5, 32'd2);
    check_eq("b2b_busy", 32'(Busy), 32'd1);
    wait_done();
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      if (i % 3 == 0) ra = 32'($urandom_range(0, 1000)) - 32'd500;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i == 4) rb = 32'hffff_fffd;
      issue(rop, ra, rb, ref_op(rop, ra, rb));
      wait_done();
    end
    wait_drain();

    // Asynchronous reset in the middle of an operation
    issue(OP_DIVU, 32'd1000, 32'd7, 32'd142);
    repeat (14) @(negedge Clock);
    #2;
    nReset = 1'b0;
    #1;
    check_eq("abort_busy", 32'(Busy), 32'd0);
    check_eq("abort_done", 32'(Done), 32'd0);
    check_eq("abort_result", Result, 32'd0);
    exp_q.delete();
    issue_q.delete();
    done_val = 32'd0;
    @(negedge Clock);
    nReset = 1'b1;
    saved  = done_cnt;
    repeat (45) @(negedge Clock);
    check_eq("no_done_after_abort", 32'(done_cnt - saved), 32'd0);
    check_eq("idle_after_abort", 32'(Busy), 32'd0);

    issue(OP_DIV, 32'd100, 32'hffff_fff9, 32'hffff_fff2);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
